morse_decoder: RTL
==================

// Module: morse_decoder
// PURPOSE
//   Decodes on-off keyed Morse (one bit, high = key down) into 8-bit ASCII characters with a one-cycle strobe.
//   Receive-side counterpart of the PS/2-to-Morse encoder path; timing units match the encoder's dot length.
//   Output feeds a character consumer (display/UART) that takes each strobe with no backpressure.
// PARAMETERS
//   UNIT_CYCLES    24'd10_000_000  clock cycles per Morse unit (dot length); must be >= 2
// PORTS
//   clk          input   1  system clock; sole clock domain
//   rst_n        input   1  asynchronous, active-low reset
//   morse_in     input   1  keyed Morse line, asynchronous to clk, 1 = mark
//   char_data    output  8  decoded ASCII character, valid while char_valid = 1
//   char_valid   output  1  one-cycle strobe, one pulse per character
//   busy         output  1  1 while a letter is being received (state MARK or GAP)
// BEHAVIOUR
//   Reset: char_data = 8'h00, char_valid = 0, busy = 0, state IDLE, element buffer empty, counters 0, sync flops 0.
//   Reset mid-operation discards the partial letter; no character is emitted for it.
//   Input: 2-flop synchronizer, then edge detect on the synchronized value; edges are seen 3 cycles after the pin.
//   Timing: prescaler counts 0..UNIT_CYCLES-1; on wrap, unit_cnt (3 bits) increments, saturating at 7.
//     Both counters clear on every synchronized edge.
//   FSM:
//     IDLE: rising edge -> MARK.
//     MARK: falling edge -> GAP; append element: dash if unit_cnt >= 2, else dot.
//     GAP:  rising edge -> MARK; unit_cnt reaching 2 with len > 0 -> emit letter and clear buffer.
//           unit_cnt reaching 5 -> IDLE.
//   Element buffer: len (3 bits, 0..6) and pat[5:0] (dot = 0, dash = 1), shifted in at the LSB.
//     The first element ends up at pat[len-1].
//     A 7th element sets sticky ovf; len holds at 6.
//   Letter emit: char_data = LUT(len, pat), or 8'h3F ('?') when ovf is set or the pattern is unknown.
//     char_valid pulses in the cycle after the threshold cycle.
//     Emit clears len, pat and ovf.
//   LUT covers A-Z (8'h41-8'h5A) and 0-9 (8'h30-8'h39) only.
//   Simultaneous events: a rising edge in the same cycle as the 2-unit gap threshold wins.
//     No emit; the element joins the current letter.
//   A very long mark saturates unit_cnt at 7 and is still a dash.
//   char_data holds its last value between strobes.
// CONFIGURATION
//   MORSE_WORD_SPACE_EN defined:
//     On GAP reaching unit_cnt = 5, emit char_data = 8'h20 with char_valid.
//     Only if at least one letter was emitted since the last space (flag letter_since_space).
//     At most one space per word gap; no space after reset before the first letter.
//   MORSE_WORD_SPACE_EN undefined:
//     Word gap only returns the FSM to IDLE; never emits 8'h20; flag logic absent.
// STRUCTURE
//   Package morse_pkg:
//     state enum (IDLE, MARK, GAP)
//     DASH_UNITS = 2, LETTER_GAP_UNITS = 2, WORD_GAP_UNITS = 5, MAX_ELEMENTS = 6
//     ASCII_UNKNOWN = 8'h3F, ASCII_SPACE = 8'h20
//   Sub-module morse_lut: purely combinational (len[2:0], pat[5:0]) -> {hit, ascii[7:0]}.
//   Top contains: synchronizer, counters, FSM, buffer, output register.
// TESTING (bench uses UNIT_CYCLES = 4, sampling char_valid each cycle)
//   1. Mark 4 cyc, gap 4, mark 12, then idle 40 -> exactly one strobe, char_data = 8'h41 ('A').
//   2. Dots 4 cyc, gaps 4 -> 8'h48 ('H').
//      5 dashes of 12 cyc, gaps 4 -> 8'h30 ('0').
//      Letters separated by 12-cyc gap -> two strobes in order.
//   3. Seven dots -> one strobe, 8'h3F.
//      Pattern ..-- (len 4, unknown) -> 8'h3F.
//   4. Single dot then idle 40 -> 8'h45, then 8'h20 with MORSE_WORD_SPACE_EN defined, 8'h45 only without.
//      Further idle produces nothing.
//   5. rst_n low during a 12-cyc mark -> outputs reset immediately.
//      Idle 40 after release -> no strobe, busy = 0.
//   6. Rising edge forced in the exact cycle unit_cnt hits 2 after a dot -> no emit.
//      Subsequent dash completes 'A' (8'h41).

Source files
------------

// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
//   Shared types and constants for the Morse receive path.
//   - state_t            : decoder FSM states
//   - *_UNITS            : timing thresholds in Morse units
//   - MAX_ELEMENTS       : element buffer depth
//   - ASCII_UNKNOWN/SPACE: special output characters
// -----------------------------------------------------------------------------
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        GAP  = 2'd2
    } state_t;

    // A mark lasting at least this many whole units is a dash.
    localparam logic [2:0] DASH_UNITS       = 3'd2;
    // Silence of this many units ends a letter.
    localparam logic [2:0] LETTER_GAP_UNITS = 3'd2;
    // Silence of this many units ends a word.
    localparam logic [2:0] WORD_GAP_UNITS   = 3'd5;
    // Longest pattern the buffer holds (digits are 5, margin of one).
    localparam logic [2:0] MAX_ELEMENTS     = 3'd6;

    localparam logic [7:0] ASCII_UNKNOWN    = 8'h3F;
    localparam logic [7:0] ASCII_SPACE      = 8'h20;

endpackage : morse_pkg

// File: rtl/morse_lut.sv
// -----------------------------------------------------------------------------
// morse_lut
//   Purely combinational Morse pattern to ASCII lookup.
//   Patterns are stored LSB-aligned: the first element sits at pat[len-1],
//   dot = 0, dash = 1, and bits above len-1 are zero.
// Ports
//   len   in  3  number of elements in the pattern (0..6)
//   pat   in  6  element bits
//   hit   out 1  pattern is a known letter or digit
//   ascii out 8  decoded character (8'h00 when hit = 0)
// -----------------------------------------------------------------------------
module morse_lut (
    input  logic [2:0] len,
    input  logic [5:0] pat,
    output logic       hit,
    output logic [7:0] ascii
);

    always_comb begin
        hit   = 1'b1;
        ascii = 8'h00;
        case ({len, pat})
            // one element
            {3'd1, 6'b000000}: ascii = 8'h45; // E .
            {3'd1, 6'b000001}: ascii = 8'h54; // T -
            // two elements
            {3'd2, 6'b000001}: ascii = 8'h41; // A .-
            {3'd2, 6'b000000}: ascii = 8'h49; // I ..
            {3'd2, 6'b000011}: ascii = 8'h4D; // M --
            {3'd2, 6'b000010}: ascii = 8'h4E; // N -.
            // three elements
            {3'd3, 6'b000100}: ascii = 8'h44; // D -..
            {3'd3, 6'b000110}: ascii = 8'h47; // G --.
            {3'd3, 6'b000101}: ascii = 8'h4B; // K -.-
            {3'd3, 6'b000111}: ascii = 8'h4F; // O ---
            {3'd3, 6'b000010}: ascii = 8'h52; // R .-.
            {3'd3, 6'b000000}: ascii = 8'h53; // S ...
            {3'd3, 6'b000001}: ascii = 8'h55; // U ..-
            {3'd3, 6'b000011}: ascii = 8'h57; // W .--
            // four elements
            {3'd4, 6'b001000}: ascii = 8'h42; // B -...
            {3'd4, 6'b001010}: ascii = 8'h43; // C -.-.
            {3'd4, 6'b000010}: ascii = 8'h46; // F ..-.
            {3'd4, 6'b000000}: ascii = 8'h48; // H ....
            {3'd4, 6'b000111}: ascii = 8'h4A; // J .---
            {3'd4, 6'b000100}: ascii = 8'h4C; // L .-..
            {3'd4, 6'b000110}: ascii = 8'h50; // P .--.
            {3'd4, 6'b001101}: ascii = 8'h51; // Q --.-
            {3'd4, 6'b000001}: ascii = 8'h56; // V ...-
            {3'd4, 6'b001001}: ascii = 8'h58; // X -..-
            {3'd4, 6'b001011}: ascii = 8'h59; // Y -.--
            {3'd4, 6'b001100}: ascii = 8'h5A; // Z --..
            // five elements: digits
            {3'd5, 6'b011111}: ascii = 8'h30; // 0 -----
            {3'd5, 6'b001111}: ascii = 8'h31; // 1 .----
            {3'd5, 6'b000111}: ascii = 8'h32; // 2 ..---
            {3'd5, 6'b000011}: ascii = 8'h33; // 3 ...--
            {3'd5, 6'b000001}: ascii = 8'h34; // 4 ....-
            {3'd5, 6'b000000}: ascii = 8'h35; // 5 .....
            {3'd5, 6'b010000}: ascii = 8'h36; // 6 -....
            {3'd5, 6'b011000}: ascii = 8'h37; // 7 --...
            {3'd5, 6'b011100}: ascii = 8'h38; // 8 ---..
            {3'd5, 6'b011110}: ascii = 8'h39; // 9 ----.
            default: begin
                hit   = 1'b0;
                ascii = 8'h00;
            end
        endcase
    end

endmodule : morse_lut

// File: rtl/morse_decoder.sv
// -----------------------------------------------------------------------------
// morse_decoder
//   Decodes an on-off keyed Morse line into ASCII characters.
//   Input is synchronized (2 flops) and edge detected; a prescaler produces
//   unit ticks that advance a saturating unit counter, cleared on every edge.
//   Mark length classifies dot/dash, gap length ends letters and words.
//
//   Output handshake: char_valid is a one-cycle strobe with char_data valid in
//   the same cycle; the consumer has no ready and must take every strobe.
//   char_data holds its last value between strobes.
//
// Parameters
//   UNIT_CYCLES  clock cycles per Morse unit (dot length), must be >= 2
// Ports
//   clk         in  1  system clock
//   rst_n       in  1  asynchronous active-low reset
//   morse_in    in  1  keyed line, asynchronous, 1 = mark
//   char_data   out 8  decoded character
//   char_valid  out 1  one-cycle strobe per character
//   busy        out 1  letter reception in progress (MARK or GAP)
//
// Configuration
//   MORSE_WORD_SPACE_EN : when defined, a word gap following at least one
//   letter emits a single space character (8'h20).
//
// The current FSM state is available as the internal signal `state` for
// hierarchical observation.
// -----------------------------------------------------------------------------
module morse_decoder
    import morse_pkg::*;
#(
    parameter logic [23:0] UNIT_CYCLES = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       morse_in,
    output logic [7:0] char_data,
    output logic       char_valid,
    output logic       busy
);

    localparam logic [23:0] PRESCALE_MAX = UNIT_CYCLES - 24'd1;

    // ---------------------------------------------------------------- sync
    logic sync_1, sync_2, sync_prev;
    logic rise, fall, any_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_1    <= morse_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign rise     = sync_2 & ~sync_prev;
    assign fall     = ~sync_2 & sync_prev;
    assign any_edge = rise | fall;

    // ------------------------------------------------------------ counters
    logic [23:0] prescale;
    logic [2:0]  unit_cnt;
    logic        unit_tick;
    logic        letter_thresh;
    logic        word_thresh;

    assign unit_tick = (prescale == PRESCALE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= 24'd0;
            unit_cnt <= 3'd0;
        end else if (any_edge) begin
            prescale <= 24'd0;
            unit_cnt <= 3'd0;
        end else if (unit_tick) begin
            prescale <= 24'd0;
            if (unit_cnt != 3'd7) begin
                unit_cnt <= unit_cnt + 3'd1;
            end
        end else begin
            prescale <= prescale + 24'd1;
        end
    end

    // Threshold cycles: the tick that moves unit_cnt onto the threshold value.
    assign letter_thresh = unit_tick && (unit_cnt == LETTER_GAP_UNITS - 3'd1);
    assign word_thresh   = unit_tick && (unit_cnt == WORD_GAP_UNITS - 3'd1);

    // ------------------------------------------------------------- buffer
    logic [2:0] len;
    logic [5:0] pat;
    logic       ovf;
    logic       is_dash;
    logic       lut_hit;
    logic [7:0] lut_ascii;

    assign is_dash = (unit_cnt >= DASH_UNITS);

    morse_lut u_lut (
        .len   (len),
        .pat   (pat),
        .hit   (lut_hit),
        .ascii (lut_ascii)
    );

    // ---------------------------------------------------------------- FSM
    state_t state, state_next;
    logic   append;
    logic   emit_letter;
    logic   emit_space;

`ifdef MORSE_WORD_SPACE_EN
    logic letter_since_space;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        append      = 1'b0;
        emit_letter = 1'b0;
        emit_space  = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = MARK;
                end
            end
            MARK: begin
                if (fall) begin
                    state_next = GAP;
                    append     = 1'b1;
                end
            end
            GAP: begin
                // A rising edge beats a coincident threshold: the new element
                // belongs to the current letter.
                if (rise) begin
                    state_next = MARK;
                end else if (letter_thresh && (len != 3'd0)) begin
                    emit_letter = 1'b1;
                end else if (word_thresh) begin
                    state_next = IDLE;
`ifdef MORSE_WORD_SPACE_EN
                    emit_space = letter_since_space;
`endif
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len <= 3'd0;
            pat <= 6'd0;
            ovf <= 1'b0;
        end else if (emit_letter) begin
            len <= 3'd0;
            pat <= 6'd0;
            ovf <= 1'b0;
        end else if (append) begin
            if (len == MAX_ELEMENTS) begin
                // Too many elements: remember it, keep the buffer as is.
                ovf <= 1'b1;
            end else begin
                len <= len + 3'd1;
                pat <= {pat[4:0], is_dash};
            end
        end
    end

`ifdef MORSE_WORD_SPACE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            letter_since_space <= 1'b0;
        end else if (emit_letter) begin
            letter_since_space <= 1'b1;
        end else if (emit_space) begin
            letter_since_space <= 1'b0;
        end
    end
`endif

    // -------------------------------------------------------------- output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_data  <= 8'h00;
            char_valid <= 1'b0;
        end else begin
            char_valid <= emit_letter | emit_space;
            if (emit_letter) begin
                char_data <= (ovf || !lut_hit) ? ASCII_UNKNOWN : lut_ascii;
            end else if (emit_space) begin
                char_data <= ASCII_SPACE;
            end
        end
    end

endmodule : morse_decoder
